// File: rtl/tdc_hit_packer_if.sv
// Output beat stream of the TDC hit packer: payload plus valid/ready handshake.
interface tdc_hit_packer_if #(
  parameter int unsigned TOF_W = 10,
  parameter int unsigned INT_W = 5,
  parameter int unsigned NUM_W = 2
);
  logic [TOF_W-1:0] o_data;
  logic [INT_W-1:0] o_int;
  logic [NUM_W-1:0] o_num;
  logic             o_ovf;
  logic             o_last;
  logic             o_valid;
  logic             o_ready;

  modport master (
    output o_data, o_int, o_num, o_ovf, o_last, o_valid,
    input  o_ready
  );

  modport slave (
    input  o_data, o_int, o_num, o_ovf, o_last, o_valid,
    output o_ready
  );
endinterface

// File: rtl/tdc_hit_packer.sv
// Multi-hit TDC result buffer: computes range-checked TOF and popcount intensity
// per hit, buffers up to MAX_HITS per frame and streams them out with back-pressure.
module tdc_hit_packer #(
  parameter int unsigned COARSE_W = 5,
  parameter int unsigned FINE_W   = 5,
  parameter int unsigned MAX_HITS = 3,
  parameter int unsigned SPAD_N   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         frame_end,
  input  logic [COARSE_W+FINE_W-1:0]   range,
  input  logic                         keep_last,
  input  logic                         hit_valid,
  input  logic [COARSE_W-1:0]          hit_coarse,
  input  logic [FINE_W-1:0]            hit_start_fine,
  input  logic [FINE_W-1:0]            hit_stop_fine,
  input  logic [SPAD_N-1:0]            hit_spaden,
  tdc_hit_packer_if.master             stream,
  output logic                         tdc_int,
  input  logic                         int_clr
);

  localparam int unsigned TOF_W = COARSE_W + FINE_W;
  localparam int unsigned INT_W = $clog2(SPAD_N + 1);
  localparam int unsigned NUM_W = $clog2(MAX_HITS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_t;

  state_t           state_q, state_d;
  logic [NUM_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] beat_q, beat_d;
  logic             lost_q, lost_d;
  logic [TOF_W-1:0] range_q, range_d;
  logic             keep_q, keep_d;
  logic [TOF_W-1:0] tof_q [MAX_HITS];
  logic [TOF_W-1:0] tof_d [MAX_HITS];
  logic [INT_W-1:0] ints_q [MAX_HITS];
  logic [INT_W-1:0] ints_d [MAX_HITS];

  logic [TOF_W-1:0] out_data_q, out_data_d;
  logic [INT_W-1:0] out_int_q, out_int_d;
  logic [NUM_W-1:0] out_num_q, out_num_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic             tdc_int_d;

  logic [TOF_W-1:0] hit_raw_c;
  logic [TOF_W-1:0] range_eff_c;
  logic [TOF_W-1:0] hit_tof_c;
  logic [INT_W-1:0] hit_int_c;
  logic             frame_done_c;

  assign stream.o_data  = out_data_q;
  assign stream.o_int   = out_int_q;
  assign stream.o_num   = out_num_q;
  assign stream.o_ovf   = out_ovf_q;
  assign stream.o_last  = out_last_q;
  assign stream.o_valid = out_valid_q;

  // Raw time of flight with modulo wrap, saturated to all-ones beyond the frame range.
  assign hit_raw_c    = {hit_coarse, hit_stop_fine} - {COARSE_W'(1), hit_start_fine};
  assign range_eff_c  = (state_q == COLLECT && frame_start) ? range : range_q;
  assign hit_tof_c    = (hit_raw_c > range_eff_c) ? '1 : hit_raw_c;
  assign frame_done_c = (state_q == COLLECT) && frame_end && !frame_start;

  // Intensity is the number of enabled SPADs at hit time.
  always_comb begin
    hit_int_c = '0;
    for (int i = 0; i < int'(SPAD_N); i++) begin
      hit_int_c = hit_int_c + INT_W'(hit_spaden[i]);
    end
  end

  // Next-state, buffer and output-beat logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    lost_d      = lost_q;
    range_d     = range_q;
    keep_d      = keep_q;
    tof_d       = tof_q;
    ints_d      = ints_q;
    out_data_d  = out_data_q;
    out_int_d   = out_int_q;
    out_num_d   = out_num_q;
    out_ovf_d   = out_ovf_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    tdc_int_d   = tdc_int;

    // Opening or restarting a frame clears the buffer and latches frame settings.
    if ((state_q == IDLE || state_q == COLLECT) && frame_start) begin
      state_d = COLLECT;
      cnt_d   = '0;
      lost_d  = 1'b0;
      range_d = range;
      keep_d  = keep_last;
      for (int i = 0; i < int'(MAX_HITS); i++) begin
        tof_d[i]  = '0;
        ints_d[i] = '0;
      end
    end

    case (state_q)
      COLLECT: begin
        if (hit_valid) begin
          if (cnt_d < NUM_W'(MAX_HITS)) begin
            for (int i = 0; i < int'(MAX_HITS); i++) begin
              if (NUM_W'(i) == cnt_d) begin
                tof_d[i]  = hit_tof_c;
                ints_d[i] = hit_int_c;
              end
            end
            cnt_d = cnt_d + NUM_W'(1);
          end else begin
            lost_d = 1'b1;
            if (keep_d) begin
              for (int i = 0; i < int'(MAX_HITS) - 1; i++) begin
                tof_d[i]  = tof_d[i+1];
                ints_d[i] = ints_d[i+1];
              end
              tof_d[MAX_HITS-1]  = hit_tof_c;
              ints_d[MAX_HITS-1] = hit_int_c;
            end
          end
        end
        // Beat 0 already reflects a hit taken in the closing cycle; empty frames give zeros.
        if (frame_done_c) begin
          state_d     = SEND;
          beat_d      = '0;
          out_valid_d = 1'b1;
          out_data_d  = tof_d[0];
          out_int_d   = ints_d[0];
          out_num_d   = cnt_d;
          out_ovf_d   = lost_d;
          out_last_d  = (cnt_d <= NUM_W'(1));
        end
      end
      SEND: begin
        if (out_valid_q && stream.o_ready) begin
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            out_int_d   = '0;
            out_num_d   = '0;
            out_ovf_d   = 1'b0;
          end else begin
            beat_d = beat_q + NUM_W'(1);
            for (int i = 0; i < int'(MAX_HITS); i++) begin
              if (NUM_W'(i) == beat_d) begin
                out_data_d = tof_q[i];
                out_int_d  = ints_q[i];
              end
            end
            out_last_d = (beat_d == cnt_q - NUM_W'(1));
          end
        end
      end
      default: ;
    endcase

    // Frame-ready interrupt: a new frame wins over a simultaneous clear.
    if (frame_done_c) begin
      tdc_int_d = 1'b1;
    end else if (int_clr) begin
      tdc_int_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      lost_q      <= 1'b0;
      range_q     <= '0;
      keep_q      <= 1'b0;
      for (int i = 0; i < int'(MAX_HITS); i++) begin
        tof_q[i]  <= '0;
        ints_q[i] <= '0;
      end
      out_data_q  <= '0;
      out_int_q   <= '0;
      out_num_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      tdc_int     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      lost_q      <= lost_d;
      range_q     <= range_d;
      keep_q      <= keep_d;
      tof_q       <= tof_d;
      ints_q      <= ints_d;
      out_data_q  <= out_data_d;
      out_int_q   <= out_int_d;
      out_num_q   <= out_num_d;
      out_ovf_q   <= out_ovf_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      tdc_int     <= tdc_int_d;
    end
  end

endmodule

// File: tb/tb_tdc_hit_packer.sv
// Bench for tdc_hit_packer: frame-level reference model checked every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_tdc_hit_packer;

  localparam int MAXH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic [9:0]  range = 10'h3FC;
  logic        keep_last = 1'b0;
  logic        hit_valid = 1'b0;
  logic [4:0]  hit_coarse = '0;
  logic [4:0]  hit_start_fine = '0;
  logic [4:0]  hit_stop_fine = '0;
  logic [15:0] hit_spaden = '0;
  logic        tdc_int;
  logic        int_clr = 1'b0;

  tdc_hit_packer_if #(.TOF_W(10), .INT_W(5), .NUM_W(2)) stream ();

  tdc_hit_packer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .range(range), .keep_last(keep_last), .hit_valid(hit_valid),
    .hit_coarse(hit_coarse), .hit_start_fine(hit_start_fine),
    .hit_stop_fine(hit_stop_fine), .hit_spaden(hit_spaden),
    .stream(stream), .tdc_int(tdc_int), .int_clr(int_clr)
  );

  always #5 clk = ~clk;

  typedef struct { int tof; int inten; } hit_t;
  typedef struct { int data; int inten; int num; int ovf; int last; } beat_t;

  int    total = 0;
  int    bad = 0;
  bit    chk_en = 1'b0;

  // Reference model state: 0 idle, 1 collecting, 2 sending.
  int    m_state = 0;
  hit_t  m_hits[$];
  beat_t m_beats[$];
  int    m_ovf = 0;
  int    m_range = 0;
  int    m_keep = 0;
  int    m_tdc = 0;

  int    seen_data[$];
  int    seen_last[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Frame-level model advanced on every clock edge from the inputs the DUT samples.
  always @(posedge clk) begin
    if (rst) begin
      m_state = 0;
      m_hits.delete();
      m_beats.delete();
      m_ovf = 0;
      m_tdc = 0;
    end else begin
      bit set_int;
      set_int = 1'b0;
      case (m_state)
        0: if (frame_start) begin
          m_state = 1; m_hits.delete(); m_ovf = 0; m_range = int'(range); m_keep = int'(keep_last);
        end
        1: begin
          if (frame_start) begin
            m_hits.delete(); m_ovf = 0; m_range = int'(range); m_keep = int'(keep_last);
          end
          if (hit_valid) begin
            hit_t h;
            int r;
            r = int'(hit_coarse) * 32 + int'(hit_stop_fine) - 32 - int'(hit_start_fine);
            r = ((r % 1024) + 1024) % 1024;
            h.tof = (r > m_range) ? 1023 : r;
            h.inten = $countones(hit_spaden);
            if (m_hits.size() < MAXH) m_hits.push_back(h);
            else begin
              m_ovf = 1;
              if (m_keep != 0) begin
                void'(m_hits.pop_front());
                m_hits.push_back(h);
              end
            end
          end
          if (frame_end && !frame_start) begin
            beat_t b;
            m_beats.delete();
            if (m_hits.size() == 0) begin
              b.data = 0; b.inten = 0; b.num = 0; b.ovf = m_ovf; b.last = 1;
              m_beats.push_back(b);
            end else begin
              foreach (m_hits[k]) begin
                b.data = m_hits[k].tof; b.inten = m_hits[k].inten; b.num = m_hits.size();
                b.ovf = m_ovf; b.last = (k == m_hits.size() - 1) ? 1 : 0;
                m_beats.push_back(b);
              end
            end
            m_state = 2;
            set_int = 1'b1;
          end
        end
        default: if (stream.o_ready) begin
          void'(m_beats.pop_front());
          if (m_beats.size() == 0) m_state = 0;
        end
      endcase
      if (set_int) m_tdc = 1;
      else if (int_clr) m_tdc = 0;
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_state == 2 && m_beats.size() > 0) begin
        chk("o_valid", int'(stream.o_valid), 1);
        chk("o_data", int'(stream.o_data), m_beats[0].data);
        chk("o_int", int'(stream.o_int), m_beats[0].inten);
        chk("o_num", int'(stream.o_num), m_beats[0].num);
        chk("o_ovf", int'(stream.o_ovf), m_beats[0].ovf);
        chk("o_last", int'(stream.o_last), m_beats[0].last);
      end else begin
        chk("o_valid_idle", int'(stream.o_valid), 0);
        chk("o_last_idle", int'(stream.o_last), 0);
        chk("o_data_idle", int'(stream.o_data), 0);
        chk("o_int_idle", int'(stream.o_int), 0);
      end
      chk("tdc_int", int'(tdc_int), m_tdc);
      if (stream.o_valid && stream.o_ready) begin
        seen_data.push_back(int'(stream.o_data));
        seen_last.push_back(int'(stream.o_last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fstart(input logic [9:0] rng, input logic kl);
    range = rng; keep_last = kl; frame_start = 1'b1;
    seen_data.delete(); seen_last.delete();
    tick();
    frame_start = 1'b0;
  endtask

  task automatic fend();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic set_hit(input int c, input int stop, input int start, input logic [15:0] sp);
    hit_coarse = 5'(c); hit_stop_fine = 5'(stop); hit_start_fine = 5'(start); hit_spaden = sp;
  endtask

  task automatic hit(input int c, input int stop, input int start, input logic [15:0] sp);
    set_hit(c, stop, start, sp);
    hit_valid = 1'b1;
    tick();
    hit_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    stream.o_ready = 1'b1;
    while (m_state != 0 && n < 20) begin
      tick();
      n++;
    end
    stream.o_ready = 1'b0;
    chk("drain_timeout", m_state, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, int'(stream.o_data), 0);
    chk({tag, "_int"}, int'(stream.o_int), 0);
    chk({tag, "_num"}, int'(stream.o_num), 0);
    chk({tag, "_ovf"}, int'(stream.o_ovf), 0);
    chk({tag, "_last"}, int'(stream.o_last), 0);
    chk({tag, "_valid"}, int'(stream.o_valid), 0);
    chk({tag, "_tdc"}, int'(tdc_int), 0);
  endtask

  initial begin
    int n;
    stream.o_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_all_zero("reset");
    chk_en = 1'b1;

    // Single hit: 3*32+4 - (32+2) = 66, popcount(0x00FF) = 8.
    fstart(10'h3FC, 1'b0);
    hit(3, 4, 2, 16'h00FF);
    fend();
    chk("t1_data", int'(stream.o_data), 66);
    chk("t1_int", int'(stream.o_int), 8);
    chk("t1_num", int'(stream.o_num), 1);
    chk("t1_last", int'(stream.o_last), 1);
    chk("t1_ovf", int'(stream.o_ovf), 0);
    chk("t1_tdc", int'(tdc_int), 1);
    tick(); tick();
    drain();
    chk("t1_beats", seen_data.size(), 1);
    chk("t1_tdc_held", int'(tdc_int), 1);
    int_clr = 1'b1; tick(); int_clr = 1'b0;
    chk("t1_tdc_clr", int'(tdc_int), 0);

    // Out-of-range and wrapped TOF both saturate with range 50.
    fstart(10'd50, 1'b0);
    hit(3, 4, 2, 16'h0001);
    hit(0, 0, 1, 16'h0000);
    fend();
    drain();
    chk("t2_beats", seen_data.size(), 2);
    if (seen_data.size() == 2) begin
      chk("t2_sat", seen_data[0], 10'h3FF);
      chk("t2_wrap", seen_data[1], 10'h3FF);
    end

    // Overflow keeping the first hits: TOFs 10,20,30,40 -> 10,20,30.
    fstart(10'h3FC, 1'b0);
    hit(1, 10, 0, 16'h0001);
    hit(1, 20, 0, 16'h0003);
    hit(1, 30, 0, 16'hFFFF);
    hit(2, 8, 0, 16'h0F0F);
    fend();
    chk("t3_num", int'(stream.o_num), 3);
    chk("t3_ovf", int'(stream.o_ovf), 1);
    drain();
    chk("t3_beats", seen_data.size(), 3);
    if (seen_data.size() == 3) begin
      chk("t3_b0", seen_data[0], 10);
      chk("t3_b1", seen_data[1], 20);
      chk("t3_b2", seen_data[2], 30);
    end

    // Overflow keeping the newest hits -> 20,30,40.
    fstart(10'h3FC, 1'b1);
    hit(1, 10, 0, 16'h0001);
    hit(1, 20, 0, 16'h0003);
    hit(1, 30, 0, 16'hFFFF);
    hit(2, 8, 0, 16'h0F0F);
    fend();
    chk("t4_ovf", int'(stream.o_ovf), 1);
    chk("t4_int0", int'(stream.o_int), 2);
    drain();
    chk("t4_beats", seen_data.size(), 3);
    if (seen_data.size() == 3) begin
      chk("t4_b0", seen_data[0], 20);
      chk("t4_b1", seen_data[1], 30);
      chk("t4_b2", seen_data[2], 40);
    end

    // Hit while idle is ignored; an empty frame gives one zero beat.
    hit(3, 4, 2, 16'hFFFF);
    fstart(10'h3FC, 1'b0);
    fend();
    chk("t5_valid", int'(stream.o_valid), 1);
    chk("t5_data", int'(stream.o_data), 0);
    chk("t5_num", int'(stream.o_num), 0);
    chk("t5_last", int'(stream.o_last), 1);
    drain();
    chk("t5_beats", seen_data.size(), 1);

    // Back-pressure: ready low 5 cycles then toggling; last hit arrives with frame_end.
    fstart(10'h3FC, 1'b0);
    hit(1, 10, 0, 16'h0001);
    hit(1, 20, 0, 16'h0003);
    set_hit(1, 30, 0, 16'h0007);
    hit_valid = 1'b1; frame_end = 1'b1;
    tick();
    hit_valid = 1'b0; frame_end = 1'b0;
    repeat (5) tick();
    n = 0;
    while (m_state != 0 && n < 40) begin
      stream.o_ready = ~stream.o_ready;
      tick();
      n++;
    end
    stream.o_ready = 1'b0;
    chk("t6_timeout", m_state, 0);
    chk("t6_beats", seen_data.size(), 3);
    if (seen_data.size() == 3) begin
      chk("t6_b2", seen_data[2], 30);
      chk("t6_last0", seen_last[0], 0);
      chk("t6_last1", seen_last[1], 0);
      chk("t6_last2", seen_last[2], 1);
    end

    // Reset while beat 1 is on the bus, then a normal frame.
    int_clr = 1'b1; tick(); int_clr = 1'b0;
    fstart(10'h3FC, 1'b0);
    hit(1, 10, 0, 16'h0001);
    hit(1, 20, 0, 16'h0003);
    hit(1, 30, 0, 16'h0007);
    fend();
    stream.o_ready = 1'b1;
    tick();
    stream.o_ready = 1'b0;
    chk("t7_beat1", int'(stream.o_data), 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("t7_rst");
    fstart(10'h3FC, 1'b0);
    hit(3, 4, 2, 16'h00FF);
    fend();
    drain();
    chk("t7_beats", seen_data.size(), 1);
    if (seen_data.size() == 1) chk("t7_data", seen_data[0], 66);

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_hit_packer.md
# tdc_hit_packer

Parametrised multi-hit TDC result buffer and stream packer for the 250 MHz logic domain. Per-hit records (coarse count plus decoded start/stop fine phase codes and SPAD enable map) are converted into range-checked time-of-flight values. Each hit gets a popcount intensity, is buffered up to `MAX_HITS` per frame, and is streamed out on a valid/ready interface with count, last and overflow flags. It generalises the fixed 3-hit, 5+5-bit TDC output path by adding configurable widths and depth, a keep-first/keep-newest overflow mode, and full back-pressure support.

## Interface
Parameters:
- `COARSE_W`, 5, coarse counter width
- `FINE_W`, 5, fine (decoded DLL phase) code width
- `MAX_HITS`, 3, hit buffer depth per frame (≥1)
- `SPAD_N`, 16, SPAD enable map width
- Derived: `TOF_W = COARSE_W+FINE_W`; `INT_W = clog2(SPAD_N+1)`; `NUM_W = clog2(MAX_HITS+1)`

Ports:
- `clk`  in  1  logic clock; one clock; reset is synchronous and active-high
- `rst`  in  1  synchronous active-high reset
- `frame_start`  in  1  one-cycle pulse: open frame, latch `range` and `keep_last`
- `frame_end`  in  1  one-cycle pulse: close frame, begin output
- `range`  in  TOF_W  maximum valid TOF
- `keep_last`  in  1  overflow mode: 0 = keep first hits, 1 = keep newest hits
- `hit_valid`  in  1  one-cycle hit strobe
- `hit_coarse`  in  COARSE_W  coarse count at hit
- `hit_start_fine`  in  FINE_W  decoded start phase
- `hit_stop_fine`  in  FINE_W  decoded stop phase
- `hit_spaden`  in  SPAD_N  SPAD enable map at hit
- `o_data`  out  TOF_W  TOF value
- `o_int`  out  INT_W  hit intensity
- `o_num`  out  NUM_W  stored hits in frame
- `o_ovf`  out  1  frame lost ≥1 hit
- `o_last`  out  1  final beat of frame
- `o_valid`  out  1  beat valid
- `o_ready`  in  1  sink ready
- `tdc_int`  out  1  frame-ready interrupt
- `int_clr`  in  1  interrupt clear pulse

## Operation
- FSM states: IDLE, COLLECT, SEND.
  - IDLE→COLLECT on `frame_start`.
  - COLLECT→SEND on `frame_end`.
  - SEND→IDLE when the `o_last` beat is accepted (`o_valid&&o_ready`).
- `frame_start` effects:
  - On entering COLLECT: clear count, `o_ovf`, buffer; latch `range_q` and `keep_last_q`.
  - In COLLECT: restarts the frame with the same clearing.
  - In SEND: ignored.
- Hits: `hit_valid` is accepted only in COLLECT, including the `frame_end` cycle. It is ignored in IDLE/SEND.
- TOF: `tof = {hit_coarse,hit_stop_fine} - {COARSE_W'd1,hit_start_fine}`, modulo 2^TOF_W (unsigned wrap). If `tof > range_q`, the stored value is all-ones.
- Intensity: popcount of `hit_spaden`, 0..SPAD_N.
- Storage: entries are in arrival order; entry 0 is the oldest.
- Overflow (count==MAX_HITS and new hit):
  - `keep_last_q=0`: drop the new hit.
  - `keep_last_q=1`: shift entries down (discard entry 0) and write the new hit at MAX_HITS-1.
  - Both cases set `o_ovf`, sticky to end of frame.
- SEND:
  - Beat k presents entry k.
  - `o_num` = count and `o_ovf` are constant for all beats.
  - `o_last=1` on beat count-1.
  - Empty frame (count==0): one beat with `o_data=0`, `o_int=0`, `o_num=0`, `o_last=1`.
- Interrupt: `tdc_int` sets on the COLLECT→SEND transition and stays high until `int_clr` (any state). Set and clear in the same cycle → set wins.

## Timing
- All outputs are registered. Reset values: `o_data=0`, `o_int=0`, `o_num=0`, `o_ovf=0`, `o_last=0`, `o_valid=0`, `tdc_int=0`; FSM=IDLE; count=0.
- `hit_valid` at cycle N → entry written at edge N+1. TOF/intensity arithmetic is single-cycle.
- `frame_end` at cycle N → `o_valid=1` with beat 0 from cycle N+1, including a hit taken in cycle N.
- Handshake:
  - A beat transfers when `o_valid&&o_ready` at a rising edge.
  - While `o_valid&&!o_ready`, all `o_*` hold stable.
  - The next beat is presented the cycle after transfer.
  - Full throughput is 1 beat/cycle.
- After the last beat transfers: `o_valid=0` and `o_last=0` next cycle; `o_data`/`o_int` return to 0.
- `o_valid` never deasserts without a transfer, except on `rst`.
- `rst` mid-frame or mid-SEND: all outputs at reset values the following cycle; partial frame discarded.

## Test plan
- Defaults (`range=10'h3FC`): hit coarse=3, stop=4, start=2, spaden=16'h00FF, then `frame_end` → one beat: `o_data=66`, `o_int=8`, `o_num=1`, `o_last=1`, `o_ovf=0`; `tdc_int=1` until `int_clr`.
- Same hit with `range=50` → `o_data=10'h3FF`. With coarse=0, stop=0, start=1 → wrap, `o_data=10'h3FF` (raw 10'h3DF > 50).
- 4 hits with TOF 10,20,30,40: `keep_last=0` → beats 10,20,30, `o_num=3`, `o_ovf=1`. `keep_last=1` → beats 20,30,40, `o_ovf=1`.
- `frame_start`→`frame_end` with no hits → single beat of zeros, `o_last=1`, `o_num=0`; `hit_valid` in IDLE changes nothing.
- 3-hit frame with `o_ready` low 5 cycles, then toggling 1/0 → each beat held stable until accepted, exactly 3 transfers, `o_last` only on the 3rd; hit coincident with `frame_end` appears as the last beat.
- `rst` asserted during beat 1 of SEND → next cycle all outputs 0, FSM IDLE; a following frame operates normally.
